// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
//
// Shares one external floating-point multiplier among NREQ requesters.
// Requesters hand over operand pairs on a valid/ready handshake; a round-robin
// arbiter issues at most one pair per cycle to the multiplier. A tag pipe that
// is MUL_LAT+1 stages deep carries the requester id alongside the operation so
// the product can be steered back into that requester's held response slot.
//
// Handshake semantics (both directions): a transfer happens on the rising edge
// where valid and ready are both high. On the request side, ready is a grant
// computed combinationally from valid, so valid must not depend on ready. On
// the response side, rsp_valid holds (with rsp_data stable) until rsp_ready.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot or 0)
//   req_a, req_b        packed operands, requester i at [i*XLEN +: XLEN]
//   mul_a, mul_b        registered operands to the multiplier
//   mul_valid           registered, marks a real issue on mul_a/mul_b
//   mul_result          product from the multiplier, MUL_LAT cycles after issue
//   rsp_valid/rsp_ready per-requester response handshake
//   rsp_data            packed held products, same packing as req_a
//   busy                any requester has an operation outstanding
// -----------------------------------------------------------------------------
module fp_mul_arbiter #(
    parameter int XLEN    = 32,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [XLEN-1:0]      mul_a,
    output logic [XLEN-1:0]      mul_b,
    output logic                 mul_valid,
    input  logic [XLEN-1:0]      mul_result,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*XLEN-1:0] rsp_data,
    output logic                 busy
);

    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TAGS = MUL_LAT + 1;

    // Registered state
    logic [NREQ-1:0]            r_pending;
    logic [IDW-1:0]             r_last_grant;
    logic [XLEN-1:0]            r_mul_a;
    logic [XLEN-1:0]            r_mul_b;
    logic                       r_mul_valid;
    logic [TAGS-1:0]            r_tag_v;
    logic [TAGS-1:0][IDW-1:0]   r_tag_id;
    logic [NREQ-1:0]            r_rsp_valid;
    logic [NREQ-1:0][XLEN-1:0]  r_rsp_data;

    // Combinational signals
    logic [NREQ-1:0]            w_elig;
    logic [NREQ-1:0]            w_grant;
    logic [NREQ-1:0]            w_consume;
    logic [IDW-1:0]             w_grant_id;
    logic [IDW-1:0]             w_idx;
    logic                       w_any;
    logic [IDW-1:0]             w_cap_id;
    logic                       w_cap;

    // (base + k) mod NREQ for k in 1..NREQ; one conditional subtract suffices
    // because base < NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // A requester whose response is consumed this cycle still reads as
    // pending here, so it can only win again next cycle.
    assign w_elig    = req_valid & ~r_pending;
    assign w_consume = r_rsp_valid & rsp_ready;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_any      = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        w_grant    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = wrap_add(r_last_grant, k);
            if (!w_any && w_elig[w_idx]) begin
                w_any      = 1'b1;
                w_grant_id = w_idx;
            end
        end
        if (!rst_n) begin
            w_any = 1'b0;
        end
        if (w_any) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    // Issue path, tag pipe, pending bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_valid  <= 1'b0;
            r_tag_v      <= '0;
            r_tag_id     <= '0;
        end else begin
            r_mul_valid <= w_any;
            if (w_any) begin
                r_mul_a      <= req_a[int'(w_grant_id)*XLEN +: XLEN];
                r_mul_b      <= req_b[int'(w_grant_id)*XLEN +: XLEN];
                r_last_grant <= w_grant_id;
            end
            // Idle cycles push an invalid tag so the pipe stays in step with
            // the multiplier's fixed latency.
            r_tag_v   <= {r_tag_v[TAGS-2:0], w_any};
            r_tag_id  <= {r_tag_id[TAGS-2:0], w_grant_id};
            // Grant needs !pending and capture needs pending, so the set and
            // clear terms never hit the same bit in one cycle.
            r_pending <= (r_pending | w_grant) & ~w_consume;
        end
    end

    assign w_cap    = r_tag_v[TAGS-1];
    assign w_cap_id = r_tag_id[TAGS-1];

    // Response slots: captured from mul_result when the last tag stage is
    // valid, held until consumed. Data is left in place after consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_cap && (w_cap_id == IDW'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= mul_result;
                end else if (w_consume[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready = w_grant;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_valid = r_mul_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = |r_pending;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arbiter
//
// Directed bench for fp_mul_arbiter. A small stand-in multiplier returns
// hand-computed IEEE-754 products for the operand pairs used here, delayed by
// MUL_LAT cycles. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. "Cycle c" of a scenario starts at that drive
// point.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

    localparam int XLEN    = 32;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [XLEN-1:0]      mul_a;
    logic [XLEN-1:0]      mul_b;
    logic                 mul_valid;
    logic [XLEN-1:0]      mul_result;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ*XLEN-1:0] rsp_data;
    logic                 busy;

    fp_mul_arbiter #(
        .XLEN    (XLEN),
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_valid  (mul_valid),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    // ---------------- multiplier stand-in ----------------
    function automatic logic [31:0] fp_prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000; // 1.5 * 2   = 3
            {32'hC0000000, 32'h3F000000}: return 32'hBF800000; // -2 * 0.5  = -1
            {32'h3F800000, 32'h40A00000}: return 32'h40A00000; // 1 * 5     = 5
            {32'h40400000, 32'h40400000}: return 32'h41100000; // 3 * 3     = 9
            {32'h40000000, 32'h40800000}: return 32'h41000000; // 2 * 4     = 8
            default:                      return a ^ b;
        endcase
    endfunction

    logic [XLEN-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= fp_prod(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mul_result = mul_pipe[MUL_LAT-1];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] slot(input logic [NREQ*XLEN-1:0] v, input int i);
        return v[i*XLEN +: XLEN];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [31:0]     e;

        // ---- reset values (req_valid high to show grant is forced off) ----
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mul_valid", 32'(mul_valid), 32'h0);
        check("rst_mul_a", mul_a, 32'h0);
        check("rst_mul_b", mul_b, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_data", 32'(|rsp_data), 32'h0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // ---- single request from requester 2 ----
        set_ops(2, 32'h3FC00000, 32'h40000000);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_grant_c0", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        req_a     = '1;  // operands need not be held after grant
        req_b     = '1;
        @(negedge clk);
        check("single_mul_valid_c1", 32'(mul_valid), 32'h1);
        check("single_mul_a_c1", mul_a, 32'h3FC00000);
        check("single_mul_b_c1", mul_b, 32'h40000000);
        check("single_busy_c1", 32'(busy), 32'h1);
        tick();
        @(negedge clk);
        check("single_rsp_valid_c2", 32'(rsp_valid), 32'h0);
        check("single_mul_valid_c2", 32'(mul_valid), 32'h0);
        tick();
        @(negedge clk);
        check("single_rsp_valid_c3", 32'(rsp_valid), 32'h4);
        check("single_rsp_data_c3", slot(rsp_data, 2), 32'h40400000);
        tick();
        @(negedge clk);
        check("single_busy_c4", 32'(busy), 32'h0);
        check("single_rsp_valid_c4", 32'(rsp_valid), 32'h0);
        check("single_rsp_data_kept_c4", slot(rsp_data, 2), 32'h40400000);
        tick();

        // ---- full contention after reset ----
        apply_reset();
        set_ops(0, 32'h3FC00000, 32'h40000000);
        set_ops(1, 32'hC0000000, 32'h3F000000);
        set_ops(2, 32'h3F800000, 32'h40A00000);
        set_ops(3, 32'h40400000, 32'h40400000);
        exp_q.push_back(32'h40400000);
        exp_q.push_back(32'hBF800000);
        exp_q.push_back(32'h40A00000);
        exp_q.push_back(32'h41100000);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("cont_ready_c%0d", c), 32'(req_ready),
                  (c < 4) ? (32'h1 << c) : 32'h0);
            check($sformatf("cont_mul_valid_c%0d", c), 32'(mul_valid),
                  (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            check($sformatf("cont_rsp_valid_c%0d", c), 32'(rsp_valid),
                  (c >= 3 && c <= 6) ? (32'h1 << (c - 3)) : 32'h0);
            if (c >= 3 && c <= 6) begin
                e = exp_q.pop_front();
                check($sformatf("cont_rsp_data%0d", c - 3), slot(rsp_data, c - 3), e);
            end
            g = req_ready;
            tick();
            req_valid = req_valid & ~g;
        end
        @(negedge clk);
        check("cont_busy_end", 32'(busy), 32'h0);
        tick();

        // ---- fairness: requesters 0 and 2 always valid ----
        set_ops(0, 32'h40000000, 32'h40800000);
        set_ops(2, 32'h3F800000, 32'h40A00000);
        req_valid = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("fair_ready_c%0d", c), 32'(req_ready),
                  (c % 4 == 0) ? 32'h1 : ((c % 4 == 1) ? 32'h4 : 32'h0));
            if (c % 4 == 3) begin
                check($sformatf("fair_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
                check($sformatf("fair_rsp_data0_c%0d", c), slot(rsp_data, 0), 32'h41000000);
            end else if (c % 4 == 0 && c >= 4) begin
                check($sformatf("fair_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h4);
                check($sformatf("fair_rsp_data2_c%0d", c), slot(rsp_data, 2), 32'h40A00000);
            end else begin
                check($sformatf("fair_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h0);
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check("fair_busy_end", 32'(busy), 32'h0);
        tick();

        // ---- backpressure on requester 1 ----
        apply_reset();
        rsp_ready = 4'b1101;
        set_ops(1, 32'hC0000000, 32'h3F000000);
        set_ops(3, 32'h40400000, 32'h40400000);
        req_valid = 4'b1010;
        for (int c = 0; c < 15; c++) begin
            if (c == 13) rsp_ready = 4'b1111;
            @(negedge clk);
            check($sformatf("bp_ready_c%0d", c), 32'(req_ready),
                  (c == 0 || c == 14) ? 32'h2 : ((c % 4 == 1) ? 32'h8 : 32'h0));
            if (c >= 3 && c <= 13) begin
                check($sformatf("bp_rsp1_valid_c%0d", c), 32'(rsp_valid[1]), 32'h1);
                check($sformatf("bp_rsp1_data_c%0d", c), slot(rsp_data, 1), 32'hBF800000);
            end
            if (c == 14) check("bp_rsp1_valid_c14", 32'(rsp_valid[1]), 32'h0);
            if (c % 4 == 0 && c >= 4) begin
                check($sformatf("bp_rsp3_valid_c%0d", c), 32'(rsp_valid[3]), 32'h1);
                check($sformatf("bp_rsp3_data_c%0d", c), slot(rsp_data, 3), 32'h41100000);
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        @(negedge clk);
        check("bp_busy_end", 32'(busy), 32'h0);
        tick();

        // ---- reset mid-flight ----
        apply_reset();
        set_ops(0, 32'h3FC00000, 32'h40000000);
        req_valid = 4'b0001;
        @(negedge clk);
        check("mid_grant_c0", 32'(req_ready), 32'h1);
        tick();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mid_rst_mul_valid", 32'(mul_valid), 32'h0);
        check("mid_rst_mul_a", mul_a, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("mid_no_rsp_c%0d", c), 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
